// File: rtl/ram4k_scan_reader_pkg.sv
// ram4k_scan_reader_pkg: RAM4K geometry and scan FSM state encoding shared by the reader and its benches
package ram4k_scan_reader_pkg;
    localparam int RAM4K_AW = 12;
    localparam int RAM4K_DW = 16;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_FIN} state_t;
endpackage

// File: rtl/ram4k_scan_reader_cmp.sv
// ram4k_scan_cmp: registered data compare with saturating mismatch count and first-error address latch
module ram4k_scan_cmp
    import ram4k_scan_reader_pkg::*;
#(
    parameter int AW = RAM4K_AW,
    parameter int DW = RAM4K_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          cap,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] expected,
    input  logic [AW-1:0] addr,
    output logic [AW:0]   mismatch_cnt,
    output logic [AW-1:0] first_err_addr
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mismatch_cnt   <= '0;
            first_err_addr <= '0;
        end else if (cap && data != expected) begin
            if (mismatch_cnt == '0) first_err_addr <= addr;
            if (~&mismatch_cnt) mismatch_cnt <= mismatch_cnt + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/ram4k_scan_reader.sv
// ram4k_scan_reader: strided RAM4K read-back with valid/ready word stream and pattern check
module ram4k_scan_reader
    import ram4k_scan_reader_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = RAM4K_AW,
    parameter int DW     = RAM4K_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    input  logic [AW:0]   count,
    input  logic [DW-1:0] exp_base,
    output logic          ram_e,
    output logic          ram_w,
    output logic          ram_r,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   mismatch_cnt,
    output logic [AW-1:0] first_err_addr
);
    state_t state, nxt;
    logic [AW-1:0] addr, stride_q;
    logic [AW:0] count_q, index;
    logic [DW-1:0] exp_q;
    logic [2:0] wcnt;
    logic go, hs, last_wait, last_beat;

    assign go        = state == S_IDLE && start;
    assign hs        = state == S_PRESENT && rd_ready;
    assign last_wait = state == S_WAIT && wcnt == 3'(RD_LAT - 1);
    assign last_beat = index + (AW+1)'(1) == count_q;

    assign busy     = state inside {S_ISSUE, S_WAIT, S_PRESENT};
    assign ram_e    = busy;
    assign ram_r    = state == S_ISSUE;
    assign ram_w    = 1'b0;
    assign ram_din  = '0;
    assign ram_addr = addr;
    assign rd_valid = state == S_PRESENT;
    assign done     = state == S_FIN;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = start ? (count == '0 ? S_FIN : S_ISSUE) : S_IDLE;
            S_ISSUE:   nxt = S_WAIT;
            S_WAIT:    nxt = last_wait ? S_PRESENT : S_WAIT;
            S_PRESENT: nxt = rd_ready ? (last_beat ? S_FIN : S_ISSUE) : S_PRESENT;
            S_FIN:     nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // pass is resolved on entry to FIN so it is already valid while done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            stride_q <= '0;
            count_q  <= '0;
            index    <= '0;
            exp_q    <= '0;
            wcnt     <= '0;
            rd_data  <= '0;
            pass     <= 1'b0;
        end else begin
            state <= nxt;
            wcnt  <= state == S_WAIT ? wcnt + 3'd1 : 3'd0;
            if (go) begin
                addr     <= base;
                stride_q <= stride;
                count_q  <= count;
                exp_q    <= exp_base;
                index    <= '0;
                pass     <= count == '0;
            end
            if (last_wait) rd_data <= ram_dout;
            if (hs) begin
                index <= index + (AW+1)'(1);
                addr  <= addr + stride_q;
                if (last_beat) pass <= mismatch_cnt == '0;
            end
        end
    end

    ram4k_scan_cmp #(.AW(AW), .DW(DW)) u_cmp (
        .clk            (clk),
        .rst            (rst),
        .clr            (go),
        .cap            (last_wait),
        .data           (ram_dout),
        .expected       (exp_q + DW'(index)),
        .addr           (addr),
        .mismatch_cnt   (mismatch_cnt),
        .first_err_addr (first_err_addr)
    );
endmodule

// File: tb/tb_ram4k_scan_reader.sv
// tb_ram4k_scan_reader: directed scans against a RAM4K model with queued expected beats and addresses
module tb_ram4k_scan_reader;
    import ram4k_scan_reader_pkg::*;
    localparam int AW = RAM4K_AW;
    localparam int DW = RAM4K_DW;

    logic clk = 0, rst = 1, start = 0, rd_ready = 1;
    logic [AW-1:0] base = 0, stride = 0;
    logic [AW:0] count = 0;
    logic [DW-1:0] exp_base = 0;
    logic ram_e, ram_w, ram_r, rd_valid, busy, done, pass;
    logic [AW-1:0] ram_addr, first_err_addr;
    logic [DW-1:0] ram_din, ram_dout, rd_data;
    logic [AW:0] mismatch_cnt;
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] exp_data_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int compared = 0, mismatched = 0, beats = 0;

    always #5 clk = ~clk;

    ram4k_scan_reader #(.RD_LAT(1), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride), .count(count),
        .exp_base(exp_base), .ram_e(ram_e), .ram_w(ram_w), .ram_r(ram_r), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_err_addr(first_err_addr)
    );

    always_ff @(posedge clk) if (ram_e && ram_r) ram_dout <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor: samples after the stimulus has settled its half-cycle updates
    always @(negedge clk) begin
        #2;
        if (rd_valid && rd_ready) begin
            if (exp_data_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rd_data: got unexpected beat %0d, expected none", rd_data);
            end else chk("rd_data", rd_data, exp_data_q.pop_front());
            beats++;
        end
        if (ram_r) begin
            if (exp_addr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL ram_addr: got unexpected read at %0d, expected none", ram_addr);
            end else chk("ram_addr", ram_addr, exp_addr_q.pop_front());
        end
    end

    task automatic scan(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW:0] c,
                        input logic [DW-1:0] e, input int exp_done, input logic exp_pass,
                        input int exp_cnt, input int exp_first, input bit stall, input int rst_beat);
        int n, stalls;
        logic [AW-1:0] a;
        a = b;
        for (int i = 0; i < int'(c); i++) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
            a = a + s;
        end
        beats = 0;
        stalls = 0;
        @(negedge clk);
        base = b; stride = s; count = c; exp_base = e; start = 1;
        @(posedge clk);
        #1 start = 0;
        n = 1;
        forever begin
            @(negedge clk);
            #1;
            if (n == 1) chk("mismatch_cnt after start", mismatch_cnt, 0);
            if (rst_beat >= 0 && beats == rst_beat && !rd_valid) begin
                chk("mismatch_cnt before rst", mismatch_cnt, rst_beat);
                rst = 1;
                @(posedge clk);
                @(negedge clk);
                #1;
                chk("rst flags", {rd_valid, busy, ram_e, ram_r, done, pass}, 0);
                chk("rst rd_data", rd_data, 0);
                chk("rst ram_addr", ram_addr, 0);
                chk("rst mismatch_cnt", mismatch_cnt, 0);
                chk("rst first_err_addr", first_err_addr, 0);
                rst = 0;
                exp_data_q.delete();
                exp_addr_q.delete();
                return;
            end
            if (stall && beats == 3 && stalls < 5) begin
                rd_ready = 0;
                if (rd_valid) begin
                    stalls++;
                    chk("stall rd_data", rd_data, 3);
                    chk("stall ram_r", ram_r, 0);
                end
            end else rd_ready = 1;
            if (done) break;
            if (n >= 400) begin
                compared++;
                mismatched++;
                $display("FAIL done timeout: got no done after %0d cycles, expected cycle %0d", n, exp_done);
                break;
            end
            @(posedge clk);
            n++;
        end
        chk("done cycle", n, exp_done);
        chk("pass", pass, exp_pass);
        chk("mismatch_cnt", mismatch_cnt, exp_cnt);
        chk("first_err_addr", first_err_addr, exp_first);
        chk("busy in FIN", busy, 0);
        @(negedge clk);
        #1;
        chk("done pulse width", done, 0);
        chk("pass held", pass, exp_pass);
        chk("leftover beats", exp_data_q.size(), 0);
        chk("leftover reads", exp_addr_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'hDEAD;
        for (int i = 0; i < 32; i++) mem[32*i] = DW'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset flags", {rd_valid, busy, ram_e, ram_r, ram_w, done, pass}, 0);
        chk("reset counters", {mismatch_cnt, first_err_addr}, 0);
        rst = 0;
        scan(0, 32, 32, 0, 97, 1, 0, 0, 0, -1);
        mem[320] = 100;
        scan(0, 32, 32, 0, 97, 0, 1, 320, 0, -1);
        mem[320] = 10;
        scan(0, 32, 32, 0, 102, 1, 0, 0, 1, -1);
        mem[4064] = 16'hFFFF;
        scan(4064, 32, 3, 16'hFFFF, 10, 1, 0, 0, 0, -1);
        scan(0, 32, 0, 0, 1, 1, 0, 0, 0, -1);
        scan(0, 32, 32, 1, 0, 0, 0, 0, 0, 5);
        scan(0, 32, 32, 0, 97, 1, 0, 0, 0, -1);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ram4k_scan_reader.md
Name: ram4k_scan_reader

Overview:
- Synthesizable read-back initiator for the RAM4K memory port: the reader counterpart to the block-write stimulus.
- On start, it issues reads at base + i*stride for i = 0..count-1.
- Each word goes out on a valid/ready stream and is compared against the expected pattern exp_base + i.
- It reports pass/fail, mismatch count and first failing address. Sits between RAM4K and a host/self-test controller.

Parameters:
RD_LAT, 1, cycles from ram_r asserted to ram_dout valid (1..4)
AW, 12, RAM address width
DW, 16, RAM data width

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin scan; sampled only in IDLE
base  input  AW  first address
stride  input  AW  address increment per beat
count  input  AW+1  beats to read (0..4096)
exp_base  input  DW  expected value of beat 0
ram_e  output  1  RAM enable
ram_w  output  1  RAM write strobe, tied 0
ram_r  output  1  RAM read strobe
ram_addr  output  AW  RAM address
ram_din  output  DW  RAM write data, tied 0
ram_dout  input  DW  RAM read data
rd_data  output  DW  captured word
rd_valid  output  1  rd_data valid
rd_ready  input  1  downstream accepts
busy  output  1  scan in progress
done  output  1  one-cycle pulse at scan end
pass  output  1  1 if no mismatches; held until next start
mismatch_cnt  output  AW+1  mismatches in last scan
first_err_addr  output  AW  address of first mismatch, 0 if none

Behaviour:
- Reset and synchronous reset clear all registered outputs to 0, including mid-scan: the scan is aborted and the FSM returns to IDLE. pass resets to 0.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, FIN.
- IDLE, start=1:
  - latch params; index=0, addr=base, mismatch_cnt=0, first_err_addr=0, pass=0, busy=1.
  - If count==0, go to FIN; otherwise go to ISSUE.
- ISSUE, 1 cycle: ram_e=1, ram_r=1, ram_addr=addr; go to WAIT.
- WAIT, exactly RD_LAT cycles:
  - ram_r=0; ram_addr held.
  - On the last WAIT cycle, capture ram_dout into rd_data.
  - Compare against exp_base+index (mod 2^DW). On mismatch, increment mismatch_cnt; if it was 0, set first_err_addr=addr.
  - Go to PRESENT.
- PRESENT:
  - rd_valid=1; rd_data stable; no RAM access while rd_valid && !rd_ready.
  - On the handshake: index++, addr=(addr+stride) mod 2^AW (wraps at 4096).
  - Then go to FIN if index+1==count, else ISSUE.
- FIN, 1 cycle: done=1, busy=0, pass=(mismatch_cnt==0); go to IDLE.
- Throughput: 2+RD_LAT cycles per beat with rd_ready held high. One read outstanding at a time.
- start while busy is ignored. start in the FIN cycle is ignored; it is accepted the following cycle.
- ram_e is 1 whenever busy, else 0.
- mismatch_cnt saturates at 2^(AW+1)-1.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE..S_FIN;
  - RAM4K geometry constants AW=12 and DW=16 (shared with RAM4K and its benches).
- One natural sub-module: ram4k_scan_cmp, the registered comparator plus mismatch counter and first-error latch, driven by a capture strobe.

Test Plan:
- RAM preloaded mem[32*i]=i, i=0..31; base=0, stride=32, count=32, exp_base=0, RD_LAT=1, rd_ready=1; start in cycle 0.
  -> 32 beats with rd_data=0..31; done pulses in cycle 97; pass=1; mismatch_cnt=0.
- Same as above, but mem[320]=100. -> beat 10 rd_data=100; mismatch_cnt=1; first_err_addr=320; pass=0.
- rd_ready low for 5 cycles during beat 3. -> rd_valid held, rd_data=3 stable, ram_r stays 0; the scan resumes and ends 5 cycles later than baseline.
- base=4064, stride=32, count=3. -> ram_addr sequence 4064, 0, 32 (wrap-around).
- count=0. -> no ram_r; done pulses in cycle 1; pass=1.
- rst=1 during beat 5, then a new start. -> all outputs 0 the next cycle; the fresh scan starts at base with mismatch_cnt=0.
